// File: rtl/prio_grant_enc.sv
// prio_grant_enc: registered priority encoder with valid/ready grant hold; round-robin built when PRIO_GRANT_RR_EN is defined.
module prio_grant_enc #(
    parameter int N = 8,
    localparam int W = (N > 2) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         rr_mode,
    input  logic         grant_rdy,
    output logic         grant_vld,
    output logic [W-1:0] grant_idx,
    output logic [N-1:0] grant_oh
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t state, state_nxt;
    logic hs, take, hit;
    logic [W-1:0] nxt;
    int start, best, d;
    assign hs = (state == HOLD) && grant_rdy;
    assign take = (state == IDLE) || grant_rdy;
    assign hit = |req;
`ifdef PRIO_GRANT_RR_EN
    logic [W-1:0] last, base;
    // the search on a handshake edge already sees the just-accepted index
    always_comb begin
        base = (hs && rr_mode) ? grant_idx : last;
        start = (!rr_mode || base == '0) ? N - 1 : int'(base) - 1;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) last <= '0;
        else if (hs && rr_mode) last <= grant_idx;
`else
    logic unused_rr;
    assign unused_rr = rr_mode;
    always_comb start = N - 1;
`endif
    // winner is the set bit with the smallest downward distance from start
    always_comb begin
        nxt = '0;
        best = N;
        d = 0;
        for (int i = 0; i < N; i++) begin
            d = (start >= i) ? start - i : start - i + N;
            if (req[i[W-1:0]] && d < best) begin
                best = d;
                nxt = i[W-1:0];
            end
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nxt;
    always_comb state_nxt = take ? (hit ? HOLD : IDLE) : state;
    always_ff @(posedge clk or posedge rst)
        if (rst) grant_idx <= '0;
        else if (take && hit) grant_idx <= nxt;
    always_comb begin
        grant_vld = (state == HOLD);
        grant_oh = grant_vld ? {{(N-1){1'b0}}, 1'b1} << grant_idx : '0;
    end
endmodule

// File: tb/tb_prio_grant_enc.sv
// tb_prio_grant_enc: random and directed checks of prio_grant_enc (N=8 and N=5) against a search-order model.
module tb_prio_grant_enc;
`ifdef PRIO_GRANT_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, rr_mode = 1'b0, grant_rdy = 1'b0;
    logic [7:0] req8 = '0, oh8;
    logic [4:0] req5 = '0, oh5;
    logic [2:0] idx8, idx5;
    logic vld8, vld5;
    int checks = 0, failures = 0;
    int mvld[2], midx[2], mlast[2];

    always #5 clk = ~clk;

    prio_grant_enc #(.N(8)) u8 (.clk(clk), .rst(rst), .req(req8), .rr_mode(rr_mode),
        .grant_rdy(grant_rdy), .grant_vld(vld8), .grant_idx(idx8), .grant_oh(oh8));
    prio_grant_enc #(.N(5)) u5 (.clk(clk), .rst(rst), .req(req5), .rr_mode(rr_mode),
        .grant_rdy(grant_rdy), .grant_vld(vld5), .grant_idx(idx5), .grant_oh(oh5));

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // search order: ptr-1, ptr-2, ... modulo n; ptr = 0 gives n-1 .. 0
    function automatic int pick(input int n, input longint r, input int ptr);
        for (int k = 1; k <= n; k++) begin
            int i = ((ptr - k) % n + n) % n;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            mvld[u] = 0; midx[u] = 0; mlast[u] = 0;
        end
    endtask

    task automatic compare();
        check("vld8", vld8, mvld[0]);
        check("oh8", oh8, mvld[0] ? (1 << midx[0]) : 0);
        if (mvld[0]) check("idx8", idx8, midx[0]);
        check("vld5", vld5, mvld[1]);
        check("oh5", oh5, mvld[1] ? (1 << midx[1]) : 0);
        if (mvld[1]) check("idx5", idx5, midx[1]);
    endtask

    task automatic step();
        bit rr = RR && rr_mode;
        for (int u = 0; u < 2; u++) begin
            int n = u ? 5 : 8;
            longint r = u ? longint'(req5) : longint'(req8);
            if (!mvld[u] || grant_rdy) begin
                int p;
                if (mvld[u] && rr) mlast[u] = midx[u];
                p = pick(n, r, rr ? mlast[u] : 0);
                mvld[u] = (p >= 0);
                if (p >= 0) midx[u] = p;
            end
        end
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_vld", vld8, 0);
        check("rst_idx", idx8, 0);
        check("rst_oh", oh8, 0);
        @(negedge clk);
        rst = 1'b0;
        // fixed priority
        req8 = 8'h26; req5 = 5'h06; grant_rdy = 1'b1;
        step();
        check("fix_idx5", idx8, 5);
        check("fix_oh20", oh8, 8'h20);
        step();
        check("fix_rep", idx8, 5);
        // back-pressure while req changes
        grant_rdy = 1'b0; req8 = 8'h80;
        repeat (3) step();
        check("bp_hold", idx8, 5);
        grant_rdy = 1'b1;
        step();
        check("bp_next7", idx8, 7);
        // round-robin rotation and wrap
        rr_mode = 1'b1; req8 = 8'hFF; req5 = 5'h1F;
        repeat (10) step();
        req8 = 8'h81; req5 = 5'h11;
        repeat (4) step();
        // drain, then rdy pulses in idle
        req8 = 8'h00; req5 = 5'h00;
        step();
        check("drain_vld", vld8, 0);
        check("drain_oh", oh8, 0);
        repeat (3) begin grant_rdy = ~grant_rdy; step(); end
        // async reset mid-hold
        grant_rdy = 1'b0; req8 = 8'h3C; req5 = 5'h0A;
        step();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_vld", vld8, 0);
        check("arst_oh", oh8, 0);
        check("arst_idx", idx8, 0);
        compare();
        #2 rst = 1'b0;
        rr_mode = 1'b1; req8 = 8'hFF; grant_rdy = 1'b1;
        step();
        check("arst_first7", idx8, 7);
        // random traffic
        for (int t = 0; t < 400; t++) begin
            req8 = 8'($urandom) & 8'($urandom);
            req5 = 5'($urandom) & 5'($urandom);
            rr_mode = ($urandom_range(0, 3) != 0);
            grant_rdy = ($urandom_range(0, 3) != 0);
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
